ipv4_checksum_gen: RTL and testbench

IPV4_CHECKSUM_GEN -- requirements
Module: ipv4_checksum_gen

---
 rtl/ipv4_checksum_gen.sv | 159 +++++++++++++++
 tb/tb_ipv4_checksum_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_checksum_gen.sv
// ipv4_checksum_gen: computes and inserts the IPv4 header checksum of a 20-byte header.
// Latency: accept at edge N -> hdr_out_valid after edge N + 10/WORDS_PER_CYCLE + 2.
// Backpressure: one header in flight; hdr_in_ready only in IDLE, result held in DONE until taken.
// Ports: clk/areset (async, active-high); hdr_in_valid/ready/data (160-bit header, byte 0 at [159:152]);
//        hdr_out_valid/ready/data (header with checksum in [79:64]), hdr_out_checksum,
//        hdr_out_ihl_err (byte 0 != 0x45), hdr_out_ttl_expired.
// Build option: define IPV4_CHECKSUM_GEN_TTL_DEC_EN to decrement TTL at capture and flag TTL <= 1.
// WORDS_PER_CYCLE legal values: 1, 2, 5, 10.
module ipv4_checksum_gen #(
  parameter int WORDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         hdr_in_valid,
  output logic         hdr_in_ready,
  input  logic [159:0] hdr_in_data,
  output logic         hdr_out_valid,
  input  logic         hdr_out_ready,
  output logic [159:0] hdr_out_data,
  output logic [15:0]  hdr_out_checksum,
  output logic         hdr_out_ihl_err,
  output logic         hdr_out_ttl_expired
);

  localparam int NGRP = 10 / WORDS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, SUM, FOLD, DONE} state_t;

  state_t         state_q, state_d;
  logic [159:0]   hdr_q, hdr_d;
  logic [19:0]    acc_q, acc_d;
  logic [19:0]    grp_q, grp_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [15:0]    chk_q, chk_d;
  logic           ihl_err_q, ihl_err_d;
  logic           ttl_exp_q, ttl_exp_d;
  logic           rdy_en_q;

  logic           accept;
  logic [19:0]    grp_sum;
  logic [7:0]     ttl_in, ttl_cap;
  logic           ttl_exp_cap;
  logic [16:0]    fold1;
  logic [15:0]    fold2;
  logic           unused_chk_field;

  // Word idx of the header (0 = bytes 0..1); the checksum word and out-of-range indices read as 0.
  function automatic logic [15:0] word_at(input logic [159:0] h, input int idx);
    logic [159:0] t;
    logic [15:0]  w;
    t = h << (16 * idx);
    w = '0;
    if (idx >= 0 && idx < 10 && idx != 5) w = t[159:144];
    return w;
  endfunction

  // The incoming checksum field is never used; output substitutes the computed value.
  assign unused_chk_field = ^{hdr_in_data[79:64], hdr_q[79:64]};

  // Ready is held off until the first edge after reset release.
  assign hdr_in_ready  = (state_q == IDLE) && rdy_en_q;
  assign accept        = hdr_in_valid && hdr_in_ready;
  assign hdr_out_valid = (state_q == DONE);

  assign hdr_out_data        = {hdr_q[159:80], chk_q, hdr_q[63:0]};
  assign hdr_out_checksum    = chk_q;
  assign hdr_out_ihl_err     = ihl_err_q;
  assign hdr_out_ttl_expired = ttl_exp_q;

  always_comb begin
    ttl_in = hdr_in_data[95:88];
`ifdef IPV4_CHECKSUM_GEN_TTL_DEC_EN
    ttl_cap     = (ttl_in == 8'd0) ? 8'd0 : ttl_in - 8'd1;
    ttl_exp_cap = (ttl_in <= 8'd1);
`else
    ttl_cap     = ttl_in;
    ttl_exp_cap = 1'b0;
`endif
  end

  // Group adder is registered (grp_q) so the W-wide tree stays off the accumulate path;
  // this costs one extra SUM cycle to drain the final group into acc_q.
  always_comb begin
    grp_sum = '0;
    for (int j = 0; j < WORDS_PER_CYCLE; j++) begin
      grp_sum = grp_sum + {4'd0, word_at(hdr_q, int'(cnt_q) * WORDS_PER_CYCLE + j)};
    end
  end

  // End-around carry fold; two steps cover every 20-bit accumulator value.
  assign fold1 = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    acc_d     = acc_q;
    grp_d     = grp_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    ihl_err_d = ihl_err_q;
    ttl_exp_d = ttl_exp_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          hdr_d     = {hdr_in_data[159:96], ttl_cap, hdr_in_data[87:0]};
          acc_d     = '0;
          grp_d     = '0;
          cnt_d     = '0;
          ihl_err_d = (hdr_in_data[159:152] != 8'h45);
          ttl_exp_d = ttl_exp_cap;
          state_d   = SUM;
        end
      end
      SUM: begin
        if (cnt_q != 4'd0) acc_d = acc_q + grp_q;
        if (int'(cnt_q) == NGRP) begin
          state_d = FOLD;
        end else begin
          grp_d = grp_sum;
          cnt_d = cnt_q + 4'd1;
        end
      end
      FOLD: begin
        chk_d   = ~fold2;
        state_d = DONE;
      end
      DONE: begin
        if (hdr_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      hdr_q     <= '0;
      acc_q     <= '0;
      grp_q     <= '0;
      cnt_q     <= '0;
      chk_q     <= '0;
      ihl_err_q <= 1'b0;
      ttl_exp_q <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      acc_q     <= acc_d;
      grp_q     <= grp_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      ihl_err_q <= ihl_err_d;
      ttl_exp_q <= ttl_exp_d;
      rdy_en_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ipv4_checksum_gen.sv
// Testbench for ipv4_checksum_gen: four instances (WORDS_PER_CYCLE 1, 2, 5, 10) driven in lockstep.
module tb_ipv4_checksum_gen;

  logic         clk = 1'b0;
  logic         areset;
  logic         hdr_in_valid;
  logic [159:0] hdr_in_data;
  logic         hdr_out_ready;

  logic         in_rdy  [4];
  logic         out_vld [4];
  logic [159:0] out_dat [4];
  logic [15:0]  out_chk [4];
  logic         out_ihl [4];
  logic         out_ttl [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ipv4_checksum_gen #(.WORDS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10)) u_dut (
      .clk                 (clk),
      .areset              (areset),
      .hdr_in_valid        (hdr_in_valid),
      .hdr_in_ready        (in_rdy[g]),
      .hdr_in_data         (hdr_in_data),
      .hdr_out_valid       (out_vld[g]),
      .hdr_out_ready       (hdr_out_ready),
      .hdr_out_data        (out_dat[g]),
      .hdr_out_checksum    (out_chk[g]),
      .hdr_out_ihl_err     (out_ihl[g]),
      .hdr_out_ttl_expired (out_ttl[g])
    );
  end

  function automatic int wpc(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 5 : 10;
  endfunction

  task automatic check(input string name, input int k, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (W=%0d): got %h, expected %h", name, wpc(k), act, exp);
    end
  endtask

  function automatic logic [15:0] w16(input logic [159:0] h, input int i);
    logic [159:0] t;
    t = h << (16 * i);
    return t[159:144];
  endfunction

  function automatic logic [159:0] ttl_adj(input logic [159:0] h);
    logic [159:0] r;
    r = h;
`ifdef IPV4_CHECKSUM_GEN_TTL_DEC_EN
    if (r[95:88] != 8'd0) r[95:88] = r[95:88] - 8'd1;
`endif
    return r;
  endfunction

  // Reference one's-complement sum; skip_chk ignores the checksum word.
  function automatic logic [15:0] ones_sum(input logic [159:0] h, input bit skip_chk);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 10; i++) if (!(skip_chk && i == 5)) s += 32'(w16(h, i));
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic logic [15:0] ref_chk(input logic [159:0] h);
    return ~ones_sum(ttl_adj(h), 1'b1);
  endfunction

  function automatic logic [159:0] exp_data(input logic [159:0] h, input logic [15:0] c);
    logic [159:0] r;
    r = ttl_adj(h);
    r[79:64] = c;
    return r;
  endfunction

  function automatic logic exp_ttl(input logic [159:0] h);
`ifdef IPV4_CHECKSUM_GEN_TTL_DEC_EN
    return h[95:88] <= 8'd1;
`else
    return 1'b0;
`endif
  endfunction

  // One header through all four instances; output held for stall extra cycles before ready.
  task automatic run_txn(input logic [159:0] hdr, input logic [15:0] e_chk, input logic e_ihl,
                         input logic e_ttl, input int stall);
    logic [159:0] e_dat;
    int           lat [4];
    logic [159:0] snap [4];
    logic         stable [4];
    int           waited;
    logic         all_rdy;
    e_dat = exp_data(hdr, e_chk);
    @(negedge clk);
    waited = 0;
    all_rdy = in_rdy[0] & in_rdy[1] & in_rdy[2] & in_rdy[3];
    while (!all_rdy && waited < 20) begin
      @(negedge clk);
      waited++;
      all_rdy = in_rdy[0] & in_rdy[1] & in_rdy[2] & in_rdy[3];
    end
    check("in_ready_idle", 0, 160'(all_rdy), 160'd1);
    hdr_in_data  = hdr;
    hdr_in_valid = 1'b1;
    @(negedge clk);
    hdr_in_valid = 1'b0;
    hdr_in_data  = ~hdr;
    for (int k = 0; k < 4; k++) lat[k] = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (lat[k] == 0 && out_vld[k]) lat[k] = c;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
    end
    for (int k = 0; k < 4; k++) begin
      snap[k]   = {out_dat[k][159:1], out_dat[k][0] ^ out_ihl[k] ^ out_ttl[k]};
      stable[k] = 1'b1;
    end
    repeat (stall + 1) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (!out_vld[k] || in_rdy[k] ||
            {out_dat[k][159:1], out_dat[k][0] ^ out_ihl[k] ^ out_ttl[k]} !== snap[k] ||
            out_chk[k] !== out_dat[k][79:64])
          stable[k] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      check("latency", k, 160'(lat[k]), 160'(10 / wpc(k) + 2));
      check("checksum", k, 160'(out_chk[k]), 160'(e_chk));
      check("out_data", k, out_dat[k], e_dat);
      check("ihl_err", k, 160'(out_ihl[k]), 160'(e_ihl));
      check("ttl_expired", k, 160'(out_ttl[k]), 160'(e_ttl));
      check("held_stable", k, 160'(stable[k]), 160'd1);
      check("resum", k, 160'(ones_sum(out_dat[k], 1'b0)), 160'h0FFFF);
    end
    hdr_out_ready = 1'b1;
    @(negedge clk);
    hdr_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("single_xfer", k, 160'(out_vld[k]), 160'd0);
      check("ready_after", k, 160'(in_rdy[k]), 160'd1);
    end
  endtask

  typedef struct {
    logic [159:0] hdr;
    logic [15:0]  chk;
    logic         ihl;
    logic         ttl;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [159:0] h;
    logic         seen_vld;

`ifdef IPV4_CHECKSUM_GEN_TTL_DEC_EN
    vecs[0] = '{160'h4500_0073_0000_4000_4011_1234_c0a8_0001_c0a8_00c7, 16'hB961, 1'b0, 1'b0};
    vecs[1] = '{160'h4500_0000_0000_0000_0000_0000_0000_0000_0000_0000, 16'hBAFF, 1'b0, 1'b1};
    vecs[2] = '{160'h4600_0000_0000_0000_0000_0000_0000_0000_0000_0000, 16'hB9FF, 1'b1, 1'b1};
    vecs[3] = '{160'h4500_0073_0000_4000_0111_0000_c0a8_0001_c0a8_00c7, 16'hF861, 1'b0, 1'b1};
    vecs[4] = '{160'h4500_BAFF_0000_0000_0000_0000_0000_0000_0000_0000, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{160'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'h0100, 1'b1, 1'b0};
    vecs[6] = '{160'hFFFF_FFFF_0001_0000_0000_0000_0000_0000_0000_0000, 16'hFFFE, 1'b1, 1'b1};
`else
    vecs[0] = '{160'h4500_0073_0000_4000_4011_1234_c0a8_0001_c0a8_00c7, 16'hB861, 1'b0, 1'b0};
    vecs[1] = '{160'h4500_0000_0000_0000_0000_0000_0000_0000_0000_0000, 16'hBAFF, 1'b0, 1'b0};
    vecs[2] = '{160'h4600_0000_0000_0000_0000_0000_0000_0000_0000_0000, 16'hB9FF, 1'b1, 1'b0};
    vecs[3] = '{160'h4500_0073_0000_4000_0111_0000_c0a8_0001_c0a8_00c7, 16'hF761, 1'b0, 1'b0};
    vecs[4] = '{160'h4500_BAFF_0000_0000_0000_0000_0000_0000_0000_0000, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{160'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{160'hFFFF_FFFF_0001_0000_0000_0000_0000_0000_0000_0000, 16'hFFFE, 1'b1, 1'b0};
`endif

    // Reset state, asserted with no clock edge seen yet.
    areset        = 1'b1;
    hdr_in_valid  = 1'b0;
    hdr_in_data   = '0;
    hdr_out_ready = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      check("rst_in_ready", k, 160'(in_rdy[k]), 160'd0);
      check("rst_out_valid", k, 160'(out_vld[k]), 160'd0);
      check("rst_out_data", k, out_dat[k], 160'd0);
      check("rst_checksum", k, 160'(out_chk[k]), 160'd0);
    end
    repeat (3) @(negedge clk);
    areset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) check("rdy_before_edge", k, 160'(in_rdy[k]), 160'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check("rdy_first_edge", k, 160'(in_rdy[k]), 160'd1);

    // Directed vectors; the first one gets a 5-cycle stall.
    for (int i = 0; i < 7; i++) run_txn(vecs[i].hdr, vecs[i].chk, vecs[i].ihl, vecs[i].ttl, (i == 0) ? 5 : 1);

    // Reset pulse while the header is still being summed.
    @(negedge clk);
    hdr_in_data  = vecs[3].hdr;
    hdr_in_valid = 1'b1;
    @(negedge clk);
    hdr_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    areset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("midrst_out_valid", k, 160'(out_vld[k]), 160'd0);
      check("midrst_in_ready", k, 160'(in_rdy[k]), 160'd0);
      check("midrst_out_data", k, out_dat[k], 160'd0);
    end
    @(negedge clk);
    areset        = 1'b0;
    hdr_out_ready = 1'b1;
    seen_vld      = 1'b0;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (out_vld[k]) seen_vld = 1'b1;
    end
    hdr_out_ready = 1'b0;
    check("midrst_no_output", 0, 160'(seen_vld), 160'd0);
    run_txn(vecs[0].hdr, vecs[0].chk, vecs[0].ihl, vecs[0].ttl, 0);

    // Random headers against the reference sum.
    for (int n = 0; n < 1000; n++) begin
      h = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) != 0) h[159:152] = 8'h45;
      if ($urandom_range(0, 7) == 0) h[95:88] = 8'($urandom_range(0, 2));
      run_txn(h, ref_chk(h), h[159:152] != 8'h45, exp_ttl(h), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
